// File: rtl/cfg_loader.sv
// -----------------------------------------------------------------------------
// cfg_loader
//   Configuration sequencer for the neuro-array bitstream chain. Takes bytes
//   from the host over a valid/ready handshake and shifts them MSB-first into
//   the configuration chain, pulsing the shift enable once per bit. Once
//   CHAIN_LEN bits are loaded it rotates the whole chain once (output fed back
//   to input) and compares a CRC-8 of the returned bits with the CRC-8 of the
//   loaded bits.
//
// Ports
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   start          : begin a load (only looked at in IDLE)
//   abort          : back to IDLE on the next edge, beats every other input
//   byte_in        : configuration byte, MSB goes first
//   byte_valid     : host has a byte on byte_in
//   byte_ready     : loader takes byte_in this cycle
//   cfg_en         : chain shift enable (config_en)
//   cfg_bit        : chain serial input (bs_in)
//   cfg_ret        : chain serial output (bs_out)
//   busy           : loader is running
//   done           : one-cycle pulse after a completed load and verify
//   err            : CRC mismatch of the last completed verify
//   dbg_state      : current FSM state, for debug / checkers
//
// Handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both high. byte_ready never depends on byte_valid, the host
// may hold byte_valid high indefinitely, and byte_in must be stable while
// byte_valid is high and byte_ready is low.
// -----------------------------------------------------------------------------
module cfg_loader #(
  parameter int CHAIN_LEN = 259,
  parameter int CNT_W     = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       cfg_en,
  output logic       cfg_bit,
  input  logic       cfg_ret,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SHIFT  = 3'd2,
    S_VERIFY = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);

  // CRC-8, polynomial 0x07, one bit per step.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  state_t           state,      state_nxt;
  logic [CNT_W-1:0] bit_cnt,    bit_cnt_nxt;
  logic [2:0]       bit_idx,    bit_idx_nxt;
  logic [7:0]       shbuf,      shbuf_nxt;
  logic [7:0]       crc_tx,     crc_tx_nxt;
  logic [7:0]       crc_rx,     crc_rx_nxt;
  logic             cfg_en_q,   cfg_en_nxt;
  logic             cfg_bit_q,  cfg_bit_nxt;
  logic             ready_q,    ready_nxt;
  logic             busy_q,     busy_nxt;
  logic             done_q,     done_nxt;
  logic             err_q,      err_nxt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shbuf     <= '0;
      crc_tx    <= '0;
      crc_rx    <= '0;
      cfg_en_q  <= 1'b0;
      cfg_bit_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shbuf     <= shbuf_nxt;
      crc_tx    <= crc_tx_nxt;
      crc_rx    <= crc_rx_nxt;
      cfg_en_q  <= cfg_en_nxt;
      cfg_bit_q <= cfg_bit_nxt;
      ready_q   <= ready_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and next registered outputs. The *_nxt values of cfg_en,
  // cfg_bit, byte_ready and done describe the cycle after the edge, so each
  // branch sets up what the following state has to present.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shbuf_nxt   = shbuf;
    crc_tx_nxt  = crc_tx;
    crc_rx_nxt  = crc_rx;
    cfg_en_nxt  = 1'b0;
    cfg_bit_nxt = 1'b0;
    ready_nxt   = 1'b0;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    err_nxt     = err_q;

    if (abort) begin
      // Chain keeps whatever was shifted so far; err is left alone.
      state_nxt = S_IDLE;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt   = S_FETCH;
            bit_cnt_nxt = '0;
            crc_tx_nxt  = '0;
            crc_rx_nxt  = '0;
            err_nxt     = 1'b0;
            ready_nxt   = 1'b1;
            busy_nxt    = 1'b1;
          end
        end

        S_FETCH: begin
          if (byte_valid && ready_q) begin
            // The MSB goes out straight away so that the shift enable is
            // high in the first SHIFT cycle; the buffer keeps the other seven.
            state_nxt   = S_SHIFT;
            cfg_en_nxt  = 1'b1;
            cfg_bit_nxt = byte_in[7];
            shbuf_nxt   = {byte_in[6:0], 1'b0};
            bit_idx_nxt = 3'd0;
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            crc_tx_nxt  = crc8_step(crc_tx, byte_in[7]);
          end else begin
            ready_nxt = 1'b1;
          end
        end

        S_SHIFT: begin
          // bit_idx is the position of the bit on cfg_bit now; bit_cnt already
          // counts it. The chain is full once bit_cnt reaches CHAIN_LEN, which
          // drops the unused low bits of the final byte.
          if (bit_cnt == LEN_C) begin
            state_nxt   = S_VERIFY;
            bit_cnt_nxt = '0;
            cfg_en_nxt  = 1'b1;
          end else if (bit_idx == 3'd7) begin
            state_nxt = S_FETCH;
            ready_nxt = 1'b1;
          end else begin
            cfg_en_nxt  = 1'b1;
            cfg_bit_nxt = shbuf[7];
            shbuf_nxt   = {shbuf[6:0], 1'b0};
            bit_idx_nxt = bit_idx + 3'd1;
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            crc_tx_nxt  = crc8_step(crc_tx, shbuf[7]);
          end
        end

        S_VERIFY: begin
          crc_rx_nxt = crc8_step(crc_rx, cfg_ret);
          if (bit_cnt == LAST_C) begin
            // err is taken from the CRC that includes this last returned bit
            // and becomes visible together with done.
            state_nxt   = S_FIN;
            bit_cnt_nxt = '0;
            done_nxt    = 1'b1;
            busy_nxt    = 1'b0;
            err_nxt     = (crc_tx != crc_rx_nxt);
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            cfg_en_nxt  = 1'b1;
          end
        end

        S_FIN: begin
          state_nxt = S_IDLE;
        end

        default: begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. During VERIFY the chain must receive its own output in the same
  // cycle, otherwise the loop would be CHAIN_LEN+1 long and one rotation would
  // not restore the contents; cfg_ret therefore bypasses the cfg_bit register.
  // ---------------------------------------------------------------------------
  assign cfg_bit    = (state == S_VERIFY) ? cfg_ret : cfg_bit_q;
  assign cfg_en     = cfg_en_q;
  assign byte_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_cfg_loader
//   Directed bench for cfg_loader with a behavioural CHAIN_LEN-bit chain.
//   Expected chain contents come from an expected bit queue built from the
//   byte list; cycle counts are the hand-computed figures for CHAIN_LEN = 259.
// -----------------------------------------------------------------------------
module tb_cfg_loader;

  localparam int CHAIN_LEN = 259;
  localparam int CNT_W     = 9;
  localparam int NBYTES    = (CHAIN_LEN + 7) / 8;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset, start, abort, byte_valid;
  logic [7:0] byte_in;
  logic       byte_ready, cfg_en, cfg_bit, cfg_ret, busy, done, err;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  cfg_loader #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .cfg_en     (cfg_en),
    .cfg_bit    (cfg_bit),
    .cfg_ret    (cfg_ret),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Chain model and monitors
  // ---------------------------------------------------------------------------
  logic [CHAIN_LEN-1:0] chain = '0;
  logic [CHAIN_LEN-1:0] chain_seed = '0;
  logic [CHAIN_LEN-1:0] snap_chain;
  logic                 chain_init = 1'b0;
  logic                 flip_now = 1'b0;
  logic                 flip_arm = 1'b0;
  int                   flip_at = 0;
  int                   cyc = 0;
  int                   en_cnt = 0;
  int                   done_cnt = 0;
  int                   start_cyc, en_base, done_base;
  int                   total = 0;
  int                   bad = 0;
  logic [0:0]           exp_q[$];
  logic [7:0]           bytes[NBYTES];

  assign cfg_ret = chain[CHAIN_LEN-1] ^ flip_now;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (chain_init) chain <= chain_seed;
    else if (cfg_en) chain <= {chain[CHAIN_LEN-2:0], cfg_bit};
  end

  always @(negedge clk) begin
    if (cfg_en) en_cnt = en_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
    flip_now = flip_arm && cfg_en && (en_cnt == flip_at);
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic build_exp;
    exp_q.delete();
    for (int i = 0; i < CHAIN_LEN; i++) begin
      logic [7:0] b;
      b = bytes[i / 8];
      exp_q.push_back(b[7 - (i % 8)]);
    end
  endtask

  // First bit loaded ends up at the far end of the chain.
  task automatic check_chain(input string tag);
    logic [CHAIN_LEN-1:0] e;
    int pos;
    e = '0;
    pos = CHAIN_LEN - 1;
    while (exp_q.size() > 0) begin
      e[pos] = exp_q.pop_front();
      pos--;
    end
    chk(tag, $countones(chain ^ e), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic seed_chain;
    for (int i = 0; i < CHAIN_LEN; i++) chain_seed[i] = 1'($urandom_range(0, 1));
    chain_init = 1'b1;
    @(negedge clk);
    chain_init = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
    en_base   = en_cnt;
    done_base = done_cnt;
  endtask

  task automatic feed(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      while (byte_ready !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("byte_ready", byte_ready, 1);
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(0, max_gap);
        byte_valid = 1'b0;
        repeat (g) @(negedge clk);
        chk("bp_cfg_en", cfg_en, 0);
      end
      byte_in    = bytes[i];
      byte_valid = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(output int idx);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done, 1);
    idx = cyc - start_cyc + 1;
    @(negedge clk);
  endtask

  task automatic run_load(input int max_gap, output int idx);
    seed_chain();
    build_exp();
    do_start();
    feed(NBYTES, max_gap);
    wait_done(idx);
  endtask

  task automatic fill_pattern(input logic [7:0] salt, input logic [7:0] last);
    for (int i = 0; i < NBYTES; i++) bytes[i] = 8'(i * 29) ^ salt;
    bytes[0] = 8'hA5;
    bytes[1] = 8'h3C;
    bytes[NBYTES-1] = last;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int idx;
    reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;

    // 1. reset with random inputs
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      start      = 1'($urandom_range(0, 1));
      abort      = 1'($urandom_range(0, 1));
      byte_valid = 1'($urandom_range(0, 1));
      byte_in    = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_cfg_en", cfg_en, 0);
    chk("rst_cfg_bit", cfg_bit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    @(negedge clk);

    // 2. zero load, byte_valid held high
    for (int i = 0; i < NBYTES; i++) bytes[i] = 8'h00;
    seed_chain();
    build_exp();
    do_start();
    chk("start_busy", busy, 1);
    chk("start_ready", byte_ready, 1);
    feed(NBYTES, 0);
    wait_done(idx);
    chk("zero_done_cycle", idx, 552);
    chk("zero_en_cycles", en_cnt - en_base, 2 * CHAIN_LEN);
    chk("zero_done_count", done_cnt - done_base, 1);
    chk("zero_err", err, 0);
    chk("zero_busy_after", busy, 0);
    check_chain("zero_chain");

    // 3. pattern with back-pressure; final byte 0xFF then 0xE0
    fill_pattern(8'h00, 8'hFF);
    run_load(5, idx);
    chk("pat_err", err, 0);
    chk("pat_en_cycles", en_cnt - en_base, 2 * CHAIN_LEN);
    snap_chain = chain;
    check_chain("pat_chain_ff");
    fill_pattern(8'h00, 8'hE0);
    run_load(5, idx);
    chk("pat_err_e0", err, 0);
    check_chain("pat_chain_e0");
    chk("ff_vs_e0", $countones(chain ^ snap_chain), 0);

    // 4. corruption during verify, then a clean load clears err
    fill_pattern(8'h5B, 8'h40);
    flip_at  = en_cnt + 300;
    flip_arm = 1'b1;
    run_load(0, idx);
    flip_arm = 1'b0;
    chk("corrupt_done_count", done_cnt - done_base, 1);
    chk("corrupt_err", err, 1);
    repeat (3) @(negedge clk);
    chk("corrupt_err_held", err, 1);
    fill_pattern(8'hC3, 8'h80);
    seed_chain();
    build_exp();
    do_start();
    chk("start_clears_err", err, 0);
    feed(NBYTES, 2);
    wait_done(idx);
    chk("clean_err", err, 0);
    check_chain("clean_chain");

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_ready", byte_ready, 0);

    // 5. abort after 10 bytes
    fill_pattern(8'h17, 8'hA0);
    seed_chain();
    do_start();
    feed(10, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cfg_en", cfg_en, 0);
    chk("abort_ready", byte_ready, 0);
    chk("abort_state", dbg_state, 0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - done_base, 0);
    run_load(0, idx);
    chk("after_abort_cycle", idx, 552);
    chk("after_abort_err", err, 0);
    check_chain("after_abort_chain");

    // 6. start pulsed during SHIFT and VERIFY is ignored
    fill_pattern(8'h69, 8'h20);
    seed_chain();
    build_exp();
    do_start();
    fork
      feed(NBYTES, 0);
      begin
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (394) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_done(idx);
    chk("ign_done_cycle", idx, 552);
    repeat (20) @(negedge clk);
    chk("ign_done_count", done_cnt - done_base, 1);
    chk("ign_busy", busy, 0);
    chk("ign_en_cycles", en_cnt - en_base, 2 * CHAIN_LEN);
    chk("ign_err", err, 0);
    check_chain("ign_chain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
